avalon_burst_rd_master: RTL and testbench
=========================================

// Module: avalon_burst_rd_master
// PURPOSE
//  Burst-read master that drives the read side of the Avalon bridge. It fetches num_words words from base_addr
//  in bursts of up to MAX_BURST, with multiple bursts outstanding, gated by free space in an internal FIFO.
//  Returned data leaves as a valid/ready stream toward the scaler/line-buffer logic. Overflow-free by construction.
// PARAMETERS
//  AW        17  address width, byte address
//  DW        16  data width; a multiple of 8
//  MAX_BURST 32  max words per burst, 1..32
//  FIFO_DEPTH 64 internal FIFO depth; power of 2, >= MAX_BURST
// PORTS
//  clk              in  1      clock
//  reset            in  1      async active-high reset
//  start            in  1      1-cycle pulse: latch base_addr/num_words and begin; ignored while busy
//  base_addr        in  AW     first byte address
//  num_words        in  16     words to fetch, 0..65535
//  busy             out 1      job in progress
//  done             out 1      1-cycle pulse when the last word of the job is written into the FIFO
//  rd_address       out AW     Avalon read address
//  rd_read          out 1      Avalon read request
//  rd_burstcount    out 6      Avalon burst length
//  rd_waitrequest   in  1      slave stall
//  rd_readdatavalid in  1      read-data beat valid
//  rd_read_data     in  DW     read-data beat
//  out_data         out DW     stream data, FIFO head (first-word fall-through)
//  out_valid        out 1      FIFO not empty
//  out_ready        in  1      consumer accepts; pop when out_valid&&out_ready
// BEHAVIOUR
//  Reset (async)
//   - State becomes IDLE.
//   - busy, done, rd_read, out_valid are 0; rd_address and rd_burstcount are 0.
//   - FIFO is emptied; all counters are cleared.
//  Registers
//   - req_left (16b): words not yet requested.
//   - rx_left (16b): words not yet received.
//   - outstanding (7b): words requested but not yet received.
//   - fifo_cnt: FIFO occupancy.
//  Burst sizing and credit
//   - len = min(MAX_BURST, req_left).
//   - credit = FIFO_DEPTH - fifo_cnt - outstanding.
//   - A burst issues only when credit >= len.
//  FSM states
//   - IDLE: on start with num_words!=0, latch inputs, set req_left = rx_left = num_words, go to ISSUE, busy=1.
//     On start with num_words==0, pulse done the next cycle, with no read and busy staying 0.
//   - ISSUE: if req_left==0, go to DRAIN.
//     Otherwise, when credit >= len, assert rd_read with rd_address = current address and rd_burstcount = len.
//     All three outputs are registered and held stable until a cycle with rd_read && !rd_waitrequest.
//     On that accept cycle: outstanding += len, req_left -= len, address += len*(DW/8), rd_read drops.
//     The next burst may assert on the following cycle. The credit check is made before assertion and never
//     withdrawn while stalled.
//   - DRAIN: when rx_left==0, pulse done, clear busy, go to IDLE.
//  Data path
//   - Each rd_readdatavalid beat: push rd_read_data into the FIFO, outstanding -= 1, rx_left -= 1.
//   - done fires the cycle after the final beat, from either ISSUE or DRAIN.
//   - rd_readdatavalid in IDLE (stale data after reset) is discarded and not pushed.
//   - Push and pop in the same cycle leave fifo_cnt unchanged. Pop of an empty FIFO is impossible (out_valid=0).
//   - Accept and data beat in the same cycle: outstanding changes by len-1.
//  Address
//   - Wraps modulo 2^AW; no error.
//  start while busy is ignored. Mid-job reset aborts with no done pulse.
// TESTING
//  1. base=0x100, num_words=40, out_ready=1 -> bursts (0x100,32) then (0x140,8); 40 words out in order;
//     one done pulse.
//  2. rd_waitrequest held 3 cycles on the first burst -> rd_read/rd_address/rd_burstcount stable all 4 cycles;
//     exactly one accept.
//  3. num_words=100, out_ready=0 -> bursts 32+32 accepted, then rd_read stays 0 while fifo_cnt=64;
//     after 32 pops the next 32-burst issues.
//  4. start with num_words=0 -> done high exactly 1 cycle later; rd_read never asserted; busy stays 0.
//  5. reset mid-burst with 10 words outstanding -> outputs clear immediately; stale readdatavalid beats
//     are dropped; a new start fetches correctly.
//  6. start pulsed while busy with different base -> ignored; job finishes with the original addresses
//     and count.

Source files
------------

// File: rtl/avalon_burst_rd_master.sv
// ----------------------------------------------------------------------------
// avalon_burst_rd_master
//
// Purpose:
//   Burst-read master for the read side of the Avalon bridge. A job fetches
//   num_words words starting at base_addr. The words are fetched in bursts of
//   up to MAX_BURST words, and several bursts may be outstanding at once. A
//   burst is only requested when the internal FIFO is guaranteed to have room
//   for every word already in flight plus the new burst, so the FIFO can never
//   overflow. Returned words leave as a first-word-fall-through valid/ready
//   stream.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   1-cycle pulse; latches base_addr/num_words (ignored while busy)
//   base_addr, num_words    job description (byte address, word count)
//   busy                    job in progress
//   done                    1-cycle pulse after the last word of a job enters the FIFO
//   rd_address, rd_read,    Avalon burst read request (registered, held while stalled)
//   rd_burstcount
//   rd_waitrequest          slave stall
//   rd_readdatavalid,       read-data beats
//   rd_read_data
//   out_data, out_valid,    output stream (FIFO head)
//   out_ready
// ----------------------------------------------------------------------------
module avalon_burst_rd_master #(
  parameter int AW         = 17,
  parameter int DW         = 16,
  parameter int MAX_BURST  = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   num_words,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_address,
  output logic          rd_read,
  output logic [5:0]    rd_burstcount,
  input  logic          rd_waitrequest,
  input  logic          rd_readdatavalid,
  input  logic [DW-1:0] rd_read_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int SW    = CW + 2;
  localparam int BYTES = DW / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_read_q, rd_read_d;
  logic [AW-1:0] rd_address_q, rd_address_d;
  logic [5:0]    rd_burstcount_q, rd_burstcount_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   req_left_q, req_left_d;
  logic [15:0]   rx_left_q, rx_left_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Storage array; holds data only, so it carries no reset.
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];

  logic [5:0]    len;
  logic [SW-1:0] committed;
  logic          credit_ok;
  logic          accept;
  logic          push;
  logic          pop;

  assign len       = (req_left_q > 16'(MAX_BURST)) ? 6'(MAX_BURST) : req_left_q[5:0];
  // Words already committed to FIFO space (stored or in flight) plus the
  // candidate burst must fit in the FIFO.
  assign committed = SW'(fifo_cnt_q) + SW'(outstanding_q) + SW'(len);
  assign credit_ok = committed <= SW'(FIFO_DEPTH);
  assign accept    = rd_read_q && !rd_waitrequest;
  // Beats arriving while idle are leftovers from an aborted job.
  assign push      = rd_readdatavalid && (state_q != IDLE);
  assign pop       = out_valid && out_ready;

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_read       = rd_read_q;
  assign rd_address    = rd_address_q;
  assign rd_burstcount = rd_burstcount_q;
  assign out_valid     = (fifo_cnt_q != '0);
  assign out_data      = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    rd_read_d       = rd_read_q;
    rd_address_d    = rd_address_q;
    rd_burstcount_d = rd_burstcount_q;
    addr_d          = addr_q;
    req_left_d      = req_left_q;
    rx_left_d       = rx_left_q;
    fifo_cnt_d      = fifo_cnt_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // An accepted burst moves from "to request" to "in flight".
    if (accept) begin
      rd_read_d  = 1'b0;
      req_left_d = req_left_q - 16'(rd_burstcount_q);
      addr_d     = addr_q + AW'(int'(rd_burstcount_q) * BYTES);
    end
    outstanding_d = outstanding_q
                  + (accept ? CW'(rd_burstcount_q) : CW'(0))
                  - (push   ? CW'(1)               : CW'(0));

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != 16'd0) begin
            addr_d     = base_addr;
            req_left_d = num_words;
            rx_left_d  = num_words;
            busy_d     = 1'b1;
            state_d    = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (req_left_q == 16'd0) begin
          state_d = DRAIN;
        end else if (!rd_read_q && credit_ok) begin
          // Credit is checked once here; a stalled request is never withdrawn.
          rd_read_d       = 1'b1;
          rd_address_d    = addr_q;
          rd_burstcount_d = len;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase

    // The final beat ends the job from ISSUE or DRAIN alike.
    if (push) begin
      rx_left_d = rx_left_q - 16'd1;
      if (rx_left_q == 16'd1) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rd_read_q       <= 1'b0;
      rd_address_q    <= '0;
      rd_burstcount_q <= '0;
      addr_q          <= '0;
      req_left_q      <= '0;
      rx_left_q       <= '0;
      outstanding_q   <= '0;
      fifo_cnt_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      rd_read_q       <= rd_read_d;
      rd_address_q    <= rd_address_d;
      rd_burstcount_q <= rd_burstcount_d;
      addr_q          <= addr_d;
      req_left_q      <= req_left_d;
      rx_left_q       <= rx_left_d;
      outstanding_q   <= outstanding_d;
      fifo_cnt_q      <= fifo_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rd_read_data;
  end

endmodule

// File: tb/tb_avalon_burst_rd_master.sv
// ----------------------------------------------------------------------------
// tb_avalon_burst_rd_master
//
// Bench for avalon_burst_rd_master. A behavioural Avalon slave answers bursts
// with address-derived data, a consumer drains the stream, and a job-level
// reference model lists the bursts and words each job must produce.
// ----------------------------------------------------------------------------
module tb_avalon_burst_rd_master;

  localparam int AW = 17;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   num_words;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_address;
  logic          rd_read;
  logic [5:0]    rd_burstcount;
  logic          rd_waitrequest;
  logic          rd_readdatavalid;
  logic [DW-1:0] rd_read_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  avalon_burst_rd_master dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .num_words        (num_words),
    .busy             (busy),
    .done             (done),
    .rd_address       (rd_address),
    .rd_read          (rd_read),
    .rd_burstcount    (rd_burstcount),
    .rd_waitrequest   (rd_waitrequest),
    .rd_readdatavalid (rd_readdatavalid),
    .rd_read_data     (rd_read_data),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  logic [15:0]   salt = 16'h0;
  logic [AW-1:0] pend[$];
  int            beat_pct   = 100;
  int            stall_pct  = 0;
  int            stall_left = 0;
  int            req_cyc    = 0;
  int            hold_err   = 0;
  int            reads_seen = 0;
  logic [AW-1:0] req_addr   = '0;
  logic [5:0]    req_bc     = '0;
  logic [AW-1:0] acc_addr[$];
  logic [5:0]    acc_bc[$];
  int            acc_wait[$];
  logic [AW-1:0] eb_addr[$];
  logic [5:0]    eb_bc[$];
  logic [15:0]   exp_q[$];
  int            pop_budget = -1;
  int            rdy_pct    = 100;
  int            done_cnt   = 0;

  function automatic logic [15:0] data_of(input logic [AW-1:0] a);
    return 16'(a * 17'd37) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bursts of up to 32 words at consecutive byte addresses
  // (2 bytes per word, modulo 2^17), words returned in address order.
  task automatic model_job(input logic [AW-1:0] base, input int n);
    eb_addr.delete();
    eb_bc.delete();
    for (int k = 0; k < n; k += 32) begin
      eb_addr.push_back(AW'(base + 2 * k));
      eb_bc.push_back(6'((n - k < 32) ? n - k : 32));
    end
    for (int i = 0; i < n; i++) exp_q.push_back(data_of(AW'(base + 2 * i)));
  endtask

  // Avalon slave: stalls, records accepted bursts, returns beats in order.
  initial begin
    rd_waitrequest   = 1'b0;
    rd_readdatavalid = 1'b0;
    rd_read_data     = '0;
    forever begin
      @(negedge clk);
      if (pend.size() > 0 && $urandom_range(99) < beat_pct) begin
        rd_readdatavalid = 1'b1;
        rd_read_data     = data_of(pend.pop_front());
      end else begin
        rd_readdatavalid = 1'b0;
        rd_read_data     = 16'($urandom);
      end
      if (rd_read) begin
        reads_seen++;
        if (req_cyc == 0) begin
          req_addr = rd_address;
          req_bc   = rd_burstcount;
        end else if (rd_address !== req_addr || rd_burstcount !== req_bc) begin
          hold_err++;
        end
        if (stall_left > 0) begin
          stall_left--;
          rd_waitrequest = 1'b1;
        end else if ($urandom_range(99) < stall_pct) begin
          rd_waitrequest = 1'b1;
        end else begin
          rd_waitrequest = 1'b0;
          acc_addr.push_back(rd_address);
          acc_bc.push_back(rd_burstcount);
          acc_wait.push_back(req_cyc + 1);
          for (int i = 0; i < int'(rd_burstcount); i++)
            pend.push_back(AW'(rd_address + AW'(2 * i)));
        end
        req_cyc = rd_waitrequest ? req_cyc + 1 : 0;
      end else begin
        if (req_cyc != 0) hold_err++;
        req_cyc        = 0;
        rd_waitrequest = 1'($urandom_range(1));
      end
    end
  end

  // Consumer: random ready, optional pop budget, checks every popped word.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = (pop_budget != 0) && ($urandom_range(99) < rdy_pct);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(out_valid), 32'd0);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        if (pop_budget > 0) pop_budget--;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic start_job(input logic [AW-1:0] base, input int n);
    salt = 16'($urandom);
    model_job(base, n);
    acc_addr.delete();
    acc_bc.delete();
    acc_wait.delete();
    done_cnt = 0;
    hold_err = 0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    num_words = 16'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_job(input string tag);
    int cyc;
    int nb;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_in_time"}, 32'(cyc < 4000), 32'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_hold_err"}, 32'(hold_err), 32'd0);
    chk({tag, "_burst_count"}, 32'(acc_addr.size()), 32'(eb_addr.size()));
    nb = (acc_addr.size() < eb_addr.size()) ? acc_addr.size() : eb_addr.size();
    for (int i = 0; i < nb; i++) begin
      chk({tag, "_burst_addr"}, 32'(acc_addr[i]), 32'(eb_addr[i]));
      chk({tag, "_burst_len"}, 32'(acc_bc[i]), 32'(eb_bc[i]));
    end
  endtask

  initial begin
    int cyc;
    int ok;
    logic [AW-1:0] b;

    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_read", 32'(rd_read), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_address", 32'(rd_address), 32'd0);
    chk("rst_rd_burstcount", 32'(rd_burstcount), 32'd0);
    reset = 1'b0;

    // 40 words from 0x100, no stalls, always ready
    stall_pct = 0; beat_pct = 100; rdy_pct = 100;
    start_job(17'h100, 40);
    finish_job("t1");

    // first burst stalled 3 cycles
    stall_left = 3; stall_pct = 0; beat_pct = 70; rdy_pct = 80;
    start_job(17'($urandom) & 17'h1FFFE, 20 + $urandom_range(30));
    finish_job("t2");
    chk("t2_first_hold_cycles", 32'((acc_wait.size() > 0) ? acc_wait[0] : 0), 32'd4);

    // FIFO full gating with a stalled consumer
    stall_pct = 0; beat_pct = 100; rdy_pct = 100; pop_budget = 0;
    start_job(17'h2000, 100);
    cyc = 0;
    while (!(acc_addr.size() >= 2 && pend.size() == 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (rd_read !== 1'b0 || acc_addr.size() != 2) ok = 0;
    end
    chk("t3_gated_while_full", 32'(ok), 32'd1);
    chk("t3_out_valid_full", 32'(out_valid), 32'd1);
    pop_budget = 32;
    cyc = 0;
    ok = 1;
    while (pop_budget > 0 && cyc < 2000) begin
      if (rd_read !== 1'b0 || acc_addr.size() != 2) ok = 0;
      @(negedge clk);
      cyc++;
    end
    chk("t3_gated_during_pops", 32'(ok), 32'd1);
    cyc = 0;
    while (acc_addr.size() < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_third_burst_len", 32'((acc_bc.size() >= 3) ? acc_bc[2] : 6'd0), 32'd32);
    pop_budget = -1;
    finish_job("t3");

    // zero-length job
    done_cnt = 0; reads_seen = 0;
    acc_addr.delete(); acc_bc.delete(); acc_wait.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 17'h1234; num_words = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t4_done_next_cycle", 32'(done), 32'd1);
    chk("t4_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_done_one_cycle", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    chk("t4_no_read", 32'(reads_seen), 32'd0);
    chk("t4_done_pulses", 32'(done_cnt), 32'd1);

    // reset in the middle of a job
    stall_pct = 0; beat_pct = 0; rdy_pct = 100;
    start_job(17'h0800, 60);
    cyc = 0;
    while (acc_addr.size() < 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    beat_pct = 100;
    cyc = 0;
    while (pend.size() > 10 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    beat_pct = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_rd_read", 32'(rd_read), 32'd0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_rd_address", 32'(rd_address), 32'd0);
    chk("t5_rst_rd_burstcount", 32'(rd_burstcount), 32'd0);
    req_cyc = 0;
    exp_q.delete();
    done_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    beat_pct = 100;
    cyc = 0;
    while (pend.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("t5_stale_dropped", 32'(out_valid), 32'd0);
    chk("t5_idle_after_stale", 32'(busy), 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    start_job(17'h0404, 45);
    finish_job("t5_restart");

    // start while busy is ignored
    stall_pct = 20; beat_pct = 60; rdy_pct = 70;
    b = 17'($urandom) & 17'h1FFFE;
    start_job(b, 60 + $urandom_range(30));
    repeat (4) @(negedge clk);
    start = 1'b1; base_addr = b ^ 17'h0F000; num_words = 16'd7;
    @(negedge clk);
    start = 1'b0;
    finish_job("t6");

    // address wrap
    stall_pct = 10; beat_pct = 80; rdy_pct = 90;
    start_job(17'h1FFC0, 70);
    finish_job("wrap");

    // random jobs
    for (int j = 0; j < 4; j++) begin
      stall_pct = $urandom_range(40);
      beat_pct  = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 20);
      start_job(17'($urandom), $urandom_range(150, 1));
      finish_job("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
